// File: rtl/alu_if.sv
// Opcode package and the operand/result bundle for the 8-bit ALU.
// The package sits here so it is compiled before anything that uses operand_t.
package alu_pkg;
    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        SLL = 3'd2,
        LSR = 3'd3,
        AND = 3'd4,
        OR  = 3'd5,
        XOR = 3'd6,
        EQL = 3'd7
    } operand_t;
endpackage

interface alu_if;
    import alu_pkg::*;

    logic [7:0] a_i;
    logic [7:0] b_i;
    operand_t   op_i;
    logic [7:0] alu_o;
    logic       carry_o;
    logic       zero_o;

    modport master (
        output a_i, b_i, op_i,
        input  alu_o, carry_o, zero_o
    );

    modport slave (
        input  a_i, b_i, op_i,
        output alu_o, carry_o, zero_o
    );
endinterface

// File: rtl/alu.sv
// 8-bit, eight-operation ALU with a one-cycle registered result,
// carry/borrow flag and zero flag.
module alu
    import alu_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_ni,
    alu_if.slave   bus
);

    logic [7:0] res_d;
    logic [7:0] res_q;
    logic       carry_d;
    logic       carry_q;
    logic       zero_d;
    logic       zero_q;
    logic [8:0] sum_s;
    logic [7:0] a_s;
    logic [7:0] b_s;

    function automatic logic is_zero(input logic [7:0] v);
        return (v == 8'h00);
    endfunction

    assign a_s   = bus.a_i;
    assign b_s   = bus.b_i;
    assign sum_s = {1'b0, a_s} + {1'b0, b_s};

    // Operation select; the borrow for SUB is simply a < b on unsigned operands.
    always_comb begin
        res_d   = 8'h00;
        carry_d = 1'b0;
        case (bus.op_i)
            ADD: begin
                res_d   = sum_s[7:0];
                carry_d = sum_s[8];
            end
            SUB: begin
                res_d   = a_s - b_s;
                carry_d = (a_s < b_s) ? 1'b1 : 1'b0;
            end
            SLL: res_d = a_s << b_s[2:0];
            LSR: res_d = a_s >> b_s[2:0];
            AND: res_d = a_s & b_s;
            OR:  res_d = a_s | b_s;
            XOR: res_d = a_s ^ b_s;
            EQL: res_d = {7'b000_0000, (a_s == b_s)};
            default: begin
                res_d   = 8'h00;
                carry_d = 1'b0;
            end
        endcase
        zero_d = is_zero(res_d);
    end

    // Output registers; reset clears the result and both flags.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            res_q   <= 8'h00;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            res_q   <= res_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.alu_o   = res_q;
    assign bus.carry_o = carry_q;
    assign bus.zero_o  = zero_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: the driver queues the expected registered response
// for every issued cycle, and a monitor checks it after each rising edge.
module tb_alu;
    import alu_pkg::*;

    typedef struct {
        logic [7:0] res;
        logic       carry;
        logic       zero;
        operand_t   op;
        logic       rst;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    exp_t sb[$];

    alu_if bus_if ();

    alu u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Set inputs mid-cycle and queue what the following rising edge must produce.
    task automatic issue(input logic rst, input operand_t op,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] er, input logic ec, input logic ez);
        exp_t e;
        @(negedge clk);
        rst_n       = rst;
        bus_if.op_i = op;
        bus_if.a_i  = a;
        bus_if.b_i  = b;
        e.res   = er;
        e.carry = ec;
        e.zero  = ez;
        e.op    = op;
        e.rst   = rst;
        sb.push_back(e);
    endtask

    // Monitor: one queued expectation per rising edge, compared just after it.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            tests = tests + 1;
            if (bus_if.alu_o !== e.res) begin
                fails = fails + 1;
                $display("FAIL alu_o op=%s rst_n=%0b got=%02h exp=%02h",
                         e.op.name(), e.rst, bus_if.alu_o, e.res);
            end
            tests = tests + 1;
            if (bus_if.carry_o !== e.carry) begin
                fails = fails + 1;
                $display("FAIL carry_o op=%s rst_n=%0b got=%0b exp=%0b",
                         e.op.name(), e.rst, bus_if.carry_o, e.carry);
            end
            tests = tests + 1;
            if (bus_if.zero_o !== e.zero) begin
                fails = fails + 1;
                $display("FAIL zero_o op=%s rst_n=%0b got=%0b exp=%0b",
                         e.op.name(), e.rst, bus_if.zero_o, e.zero);
            end
        end
    end

    initial begin
        tests       = 0;
        fails       = 0;
        rst_n       = 1'b0;
        bus_if.a_i  = 8'hFF;
        bus_if.b_i  = 8'h01;
        bus_if.op_i = ADD;

        // Reset holds outputs at zero despite an ADD that would carry.
        issue(1'b0, ADD, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0);
        issue(1'b0, ADD, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0);
        issue(1'b1, ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);

        // All eight ops on 5, 3.
        issue(1'b1, ADD, 8'd5, 8'd3, 8'd8,  1'b0, 1'b0);
        issue(1'b1, SUB, 8'd5, 8'd3, 8'd2,  1'b0, 1'b0);
        issue(1'b1, SLL, 8'd5, 8'd3, 8'd40, 1'b0, 1'b0);
        issue(1'b1, LSR, 8'd5, 8'd3, 8'd0,  1'b0, 1'b1);
        issue(1'b1, AND, 8'd5, 8'd3, 8'd1,  1'b0, 1'b0);
        issue(1'b1, OR,  8'd5, 8'd3, 8'd7,  1'b0, 1'b0);
        issue(1'b1, XOR, 8'd5, 8'd3, 8'd6,  1'b0, 1'b0);
        issue(1'b1, EQL, 8'd5, 8'd3, 8'd0,  1'b0, 1'b1);

        // Wraparound.
        issue(1'b1, SUB, 8'd3,   8'd5,   8'hFE, 1'b1, 1'b0);
        issue(1'b1, ADD, 8'd200, 8'd100, 8'd44, 1'b1, 1'b0);
        issue(1'b1, SUB, 8'd7,   8'd7,   8'h00, 1'b0, 1'b1);

        // Shift amount uses only b[2:0].
        issue(1'b1, SLL, 8'h81, 8'h09, 8'h02, 1'b0, 1'b0);
        issue(1'b1, LSR, 8'h80, 8'd7,  8'h01, 1'b0, 1'b0);
        issue(1'b1, LSR, 8'hA5, 8'hF8, 8'hA5, 1'b0, 1'b0);

        // Equality.
        issue(1'b1, EQL, 8'h5A, 8'h5A, 8'h01, 1'b0, 1'b0);
        issue(1'b1, EQL, 8'h5A, 8'h5B, 8'h00, 1'b0, 1'b1);

        // Reset for one edge in the middle of an XOR run.
        issue(1'b1, XOR, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0);
        issue(1'b0, XOR, 8'h3C, 8'h01, 8'h00, 1'b0, 1'b0);
        issue(1'b1, XOR, 8'h3C, 8'h01, 8'h3D, 1'b0, 1'b0);
        issue(1'b1, XOR, 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b1);

        // Drain: every queued expectation must have been consumed.
        repeat (3) @(posedge clk);
        #2;
        tests = tests + 1;
        if (sb.size() != 0) begin
            fails = fails + 1;
            $display("FAIL drain pending=%0d exp=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
